// File: rtl/clean_mode_controller_exit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clean_mode_controller_exit_pkg                                |
// | Purpose  : Shared hood mode codes and clean-cycle timing defaults, plus  |
// |            the default parameter values for the clean-mode exit block.   |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+

// Shared hood parameters. Guarded so that any file of the hood may carry the
// same definitions without clashing.
`ifndef MODE_WIDTH
`define MODE_WIDTH 3
`endif
`ifndef STAND_MODE
`define STAND_MODE 3'd0
`endif
`ifndef CLEAN_MODE
`define CLEAN_MODE 3'd2
`endif
`ifndef CLEAN_SECONDS
`define CLEAN_SECONDS 180
`endif
`ifndef CONFIRM_SECONDS
`define CONFIRM_SECONDS 5
`endif

package clean_mode_controller_exit_pkg;

  localparam int unsigned DEF_TICKS_PER_SEC   = 100_000_000;
  localparam int unsigned DEF_CLEAN_SECONDS   = `CLEAN_SECONDS;
  localparam int unsigned DEF_CONFIRM_SECONDS = `CONFIRM_SECONDS;

  // Width needed to hold a down-counter that starts at n and stops at 0.
  function automatic int unsigned count_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clean_mode_controller_exit_sec_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sec_tick_gen                                                  |
// | Purpose  : Prescaler producing a one-cycle tick every TICKS_PER_SEC      |
// |            enabled cycles. The count is held at 0 while enable is low,   |
// |            so a freshly enabled timer always gets a full first period.   |
// | Ports    : clk, rst (sync, active-high), enable -> tick                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sec_tick_gen #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (TICKS_PER_SEC < 2) ? 1 : $clog2(TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] C_TERMINAL = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tick = enable && (count_q == C_TERMINAL);

  always_comb begin
    count_d = count_q;
    if (!enable || tick) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clean_mode_controller_exit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clean_mode_controller_exit                                    |
// | Purpose  : Runs the clean-cycle seconds countdown while CLEAN_MODE is    |
// |            active and raises a level toggle asking the mode FSM to leave |
// |            CLEAN_MODE, either on completion or on a confirmed abort      |
// |            (menu press, then normal press within the confirm window).    |
// | Ports    : clk, rst                       clock / sync active-high reset |
// |            current_mode                   mode from the mode FSM         |
// |            menu_signal, normal_signal     debounced key levels           |
// |            clean_mode_controller_exit_toggle  level exit request         |
// |            clean_done, clean_aborted      one-cycle completion pulses    |
// |            confirm_pending                abort window open              |
// |            remaining_seconds              seconds left (0 when idle)     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module clean_mode_controller_exit
  import clean_mode_controller_exit_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC   = DEF_TICKS_PER_SEC,
  parameter int unsigned CLEAN_SECONDS   = DEF_CLEAN_SECONDS,
  parameter int unsigned CONFIRM_SECONDS = DEF_CONFIRM_SECONDS,
  localparam int unsigned SEC_W          = $clog2(CLEAN_SECONDS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`MODE_WIDTH-1:0] current_mode,
  input  logic                   menu_signal,
  input  logic                   normal_signal,
  output logic                   clean_mode_controller_exit_toggle,
  output logic                   clean_done,
  output logic                   clean_aborted,
  output logic                   confirm_pending,
  output logic [SEC_W-1:0]       remaining_seconds
);

  localparam int unsigned CONF_W = count_width(CONFIRM_SECONDS);
  localparam logic [SEC_W-1:0]  C_CLEAN_INIT   = SEC_W'(CLEAN_SECONDS);
  localparam logic [CONF_W-1:0] C_CONFIRM_INIT = CONF_W'(CONFIRM_SECONDS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_EXIT    = 2'd3
  } state_t;

  state_t              state_q,   state_d;
  logic [SEC_W-1:0]    remaining_q, remaining_d;
  logic [CONF_W-1:0]   confirm_q, confirm_d;
  logic                pending_q, pending_d;
  logic                toggle_q,  toggle_d;
  logic                done_q,    done_d;
  logic                aborted_q, aborted_d;
  logic                menu_signal_d_q, menu_signal_d_d;

  logic in_clean;
  logic menu_rise;
  logic counting;
  logic sec_tick;

  assign in_clean  = (current_mode == `CLEAN_MODE);
  assign menu_rise = menu_signal & ~menu_signal_d_q;
  // Gating with in_clean keeps the prescaler from advancing on the cycle the
  // mode drops out, so a later entry always starts from a clean count.
  assign counting  = in_clean && ((state_q == ST_RUNNING) || (state_q == ST_CONFIRM));

  sec_tick_gen #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_sec_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (counting),
    .tick   (sec_tick)
  );

  always_comb begin
    state_d         = state_q;
    remaining_d     = remaining_q;
    confirm_d       = confirm_q;
    pending_d       = pending_q;
    toggle_d        = toggle_q;
    done_d          = 1'b0;
    aborted_d       = 1'b0;
    menu_signal_d_d = menu_signal;

    if (!in_clean) begin
      // Mode left CLEAN_MODE: drop everything quietly, no completion pulses.
      state_d     = ST_IDLE;
      remaining_d = '0;
      confirm_d   = '0;
      pending_d   = 1'b0;
      toggle_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A menu edge on the entry cycle is deliberately not looked at.
          state_d     = ST_RUNNING;
          remaining_d = C_CLEAN_INIT;
          confirm_d   = '0;
          pending_d   = 1'b0;
          toggle_d    = 1'b0;
        end

        ST_RUNNING, ST_CONFIRM: begin
          if (sec_tick) begin
            if (remaining_q != '0) begin
              remaining_d = remaining_q - SEC_W'(1);
            end
            if ((state_q == ST_CONFIRM) && (confirm_q != '0)) begin
              confirm_d = confirm_q - CONF_W'(1);
            end
          end

          // Priority: expiry, window open, abort confirm, window timeout.
          if (sec_tick && (remaining_q == SEC_W'(1))) begin
            state_d   = ST_EXIT;
            done_d    = 1'b1;
            toggle_d  = 1'b1;
            pending_d = 1'b0;
            confirm_d = '0;
          end else if ((state_q == ST_RUNNING) && menu_rise) begin
            state_d   = ST_CONFIRM;
            confirm_d = C_CONFIRM_INIT;
            pending_d = 1'b1;
          end else if ((state_q == ST_CONFIRM) && normal_signal && !menu_signal) begin
            state_d   = ST_EXIT;
            aborted_d = 1'b1;
            toggle_d  = 1'b1;
            pending_d = 1'b0;
            confirm_d = '0;
          end else if ((state_q == ST_CONFIRM) && sec_tick && (confirm_q == CONF_W'(1))) begin
            state_d   = ST_RUNNING;
            pending_d = 1'b0;
          end
        end

        ST_EXIT: begin
          // Held until the mode FSM takes us out of CLEAN_MODE.
          toggle_d = 1'b1;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      remaining_q     <= '0;
      confirm_q       <= '0;
      pending_q       <= 1'b0;
      toggle_q        <= 1'b0;
      done_q          <= 1'b0;
      aborted_q       <= 1'b0;
      menu_signal_d_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      confirm_q       <= confirm_d;
      pending_q       <= pending_d;
      toggle_q        <= toggle_d;
      done_q          <= done_d;
      aborted_q       <= aborted_d;
      menu_signal_d_q <= menu_signal_d_d;
    end
  end

  assign clean_mode_controller_exit_toggle = toggle_q;
  assign clean_done                        = done_q;
  assign clean_aborted                     = aborted_q;
  assign confirm_pending                   = pending_q;
  assign remaining_seconds                 = remaining_q;

endmodule

`default_nettype wire

// File: tb/tb_clean_mode_controller_exit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_clean_mode_controller_exit                                 |
// | Purpose  : Self-checking bench: hand-derived vector table, directed      |
// |            corner sequences, and random stimulus against a seconds-      |
// |            elapsed reference model.                                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`ifndef MODE_WIDTH
`define MODE_WIDTH 3
`endif
`ifndef STAND_MODE
`define STAND_MODE 3'd0
`endif
`ifndef CLEAN_MODE
`define CLEAN_MODE 3'd2
`endif

module tb_clean_mode_controller_exit;

  localparam int TPS   = 4;
  localparam int CSECS = 3;
  localparam int CONF  = 2;
  localparam int SEC_W = $clog2(CSECS + 1);
  localparam logic [`MODE_WIDTH-1:0] C_CLEAN = `CLEAN_MODE;
  localparam logic [`MODE_WIDTH-1:0] C_STAND = `STAND_MODE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [`MODE_WIDTH-1:0] current_mode = `STAND_MODE;
  logic menu_signal = 1'b0;
  logic normal_signal = 1'b0;
  logic toggle, done, aborted, pending;
  logic [SEC_W-1:0] rem;

  int checks = 0;
  int failures = 0;

  clean_mode_controller_exit #(
    .TICKS_PER_SEC   (TPS),
    .CLEAN_SECONDS   (CSECS),
    .CONFIRM_SECONDS (CONF)
  ) dut (
    .clk                               (clk),
    .rst                               (rst),
    .current_mode                      (current_mode),
    .menu_signal                       (menu_signal),
    .normal_signal                     (normal_signal),
    .clean_mode_controller_exit_toggle (toggle),
    .clean_done                        (done),
    .clean_aborted                     (aborted),
    .confirm_pending                   (pending),
    .remaining_seconds                 (rem)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (seconds-elapsed view) ----------------
  // phase: 0 idle, 1 cycle in progress, 2 exit requested
  int m_phase = 0;
  int m_elapsed = 0;      // clock cycles spent counting since entry
  bit m_confirm = 0;
  int m_conf_end = 0;     // whole seconds elapsed at which the window closes
  int m_exit_rem = 0;
  bit m_prev_menu = 0;
  bit m_done = 0;
  bit m_ab = 0;

  task automatic model_step(input bit r, input logic [`MODE_WIDTH-1:0] mode,
                            input bit menu, input bit normal);
    bit rise;
    bit tk;
    int gone;
    m_done = 0;
    m_ab   = 0;
    if (r) begin
      m_phase = 0; m_elapsed = 0; m_confirm = 0; m_prev_menu = 0; m_exit_rem = 0;
      return;
    end
    rise = menu && !m_prev_menu;
    m_prev_menu = menu;
    if (mode != C_CLEAN) begin
      m_phase = 0; m_confirm = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_elapsed = 0; m_confirm = 0;
    end else if (m_phase == 1) begin
      tk = ((m_elapsed % TPS) == TPS - 1);
      m_elapsed++;
      gone = m_elapsed / TPS;
      if (tk && gone == CSECS) begin
        m_done = 1; m_phase = 2; m_exit_rem = 0; m_confirm = 0;
      end else if (!m_confirm && rise) begin
        m_confirm = 1; m_conf_end = gone + CONF;
      end else if (m_confirm && normal && !menu) begin
        m_ab = 1; m_phase = 2; m_exit_rem = CSECS - gone; m_confirm = 0;
      end else if (m_confirm && gone >= m_conf_end) begin
        m_confirm = 0;
      end
    end
  endtask

  function automatic int model_rem();
    if (m_phase == 1) return CSECS - m_elapsed / TPS;
    if (m_phase == 2) return m_exit_rem;
    return 0;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input bit tg, input bit dn, input bit ab,
                           input bit pd, input int rs);
    check({tag, ".toggle"},  32'(toggle),  32'(tg));
    check({tag, ".done"},    32'(done),    32'(dn));
    check({tag, ".aborted"}, 32'(aborted), 32'(ab));
    check({tag, ".pending"}, 32'(pending), 32'(pd));
    check({tag, ".rem"},     32'(rem),     32'(rs));
  endtask

  // Apply inputs for one clock, advance the model, sample after the edge.
  task automatic drive(input bit r, input logic [`MODE_WIDTH-1:0] mode,
                       input bit menu, input bit normal);
    rst = r; current_mode = mode; menu_signal = menu; normal_signal = normal;
    @(posedge clk);
    #1;
    model_step(r, mode, menu, normal);
  endtask

  task automatic step(input string tag, input bit r, input logic [`MODE_WIDTH-1:0] mode,
                      input bit menu, input bit normal);
    drive(r, mode, menu, normal);
    check_all(tag, m_phase == 2, m_done, m_ab, m_confirm, model_rem());
  endtask

  task automatic idle_clean(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 0, C_CLEAN, 0, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit r;
    logic [`MODE_WIDTH-1:0] mode;
    bit menu, normal;
    bit tg, dn, ab, pd;
    int rs;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit r, input logic [`MODE_WIDTH-1:0] mode, input bit menu,
                     input bit normal, input bit tg, input bit dn, input bit ab,
                     input bit pd, input int rs);
    vec_t v;
    v.r = r; v.mode = mode; v.menu = menu; v.normal = normal;
    v.tg = tg; v.dn = dn; v.ab = ab; v.pd = pd; v.rs = rs;
    vecs.push_back(v);
  endtask

  initial begin
    // reset, then natural completion
    add(1, C_STAND, 0, 0, 0, 0, 0, 0, 0);
    add(0, C_STAND, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, C_CLEAN, 0, 0, 0, 0, 0, 0, 3);
    for (int k = 0; k < 4; k++) add(0, C_CLEAN, 0, 0, 0, 0, 0, 0, 2);
    for (int k = 0; k < 4; k++) add(0, C_CLEAN, 0, 0, 0, 0, 0, 0, 1);
    add(0, C_CLEAN, 0, 0, 1, 1, 0, 0, 0);   // expiry: done + toggle together
    add(0, C_CLEAN, 0, 0, 1, 0, 0, 0, 0);   // toggle held, done was one cycle
    add(0, C_STAND, 0, 0, 0, 0, 0, 0, 0);   // mode left -> toggle clears
    // abort
    add(0, C_CLEAN, 0, 0, 0, 0, 0, 0, 3);
    add(0, C_CLEAN, 1, 0, 0, 0, 0, 1, 3);
    add(0, C_CLEAN, 0, 1, 1, 0, 1, 0, 3);
    add(0, C_CLEAN, 0, 0, 1, 0, 0, 0, 3);
    add(0, C_STAND, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].mode, vecs[i].menu, vecs[i].normal);
      check_all($sformatf("vec%0d", i), vecs[i].tg, vecs[i].dn, vecs[i].ab,
                vecs[i].pd, vecs[i].rs);
    end

    // confirm window times out, later normal press is ignored
    step("to_entry", 0, C_CLEAN, 0, 0);
    step("to_menu", 0, C_CLEAN, 1, 0);
    check("to_pending_open", 32'(pending), 32'd1);
    idle_clean("to_wait", 6);
    step("to_close", 0, C_CLEAN, 0, 0);
    check("to_pending_closed", 32'(pending), 32'd0);
    check("to_rem_after_close", 32'(rem), 32'd1);
    step("to_late_normal", 0, C_CLEAN, 0, 1);
    check("to_late_normal_toggle", 32'(toggle), 32'd0);
    idle_clean("to_run", 2);
    step("to_expire", 0, C_CLEAN, 0, 0);
    check("to_done", 32'(done), 32'd1);
    step("to_leave", 0, C_STAND, 0, 0);

    // normal press lands on the final tick while confirming: expiry wins
    step("sim_entry", 0, C_CLEAN, 0, 0);
    idle_clean("sim_run", 8);
    step("sim_menu", 0, C_CLEAN, 1, 0);
    idle_clean("sim_wait", 2);
    check("sim_pending", 32'(pending), 32'd1);
    step("sim_final", 0, C_CLEAN, 0, 1);
    check("sim_done", 32'(done), 32'd1);
    check("sim_aborted", 32'(aborted), 32'd0);
    check("sim_toggle", 32'(toggle), 32'd1);
    step("sim_leave", 0, C_STAND, 0, 0);

    // mode leaves mid-run, then re-entry restarts
    step("ml_entry", 0, C_CLEAN, 0, 0);
    idle_clean("ml_run", 4);
    check("ml_rem_before", 32'(rem), 32'd2);
    step("ml_leave", 0, C_STAND, 0, 0);
    check("ml_rem_cleared", 32'(rem), 32'd0);
    step("ml_reenter", 0, C_CLEAN, 0, 0);
    check("ml_rem_restart", 32'(rem), 32'd3);

    // reset mid-run with mode held in CLEAN
    idle_clean("rs_run", 4);
    check("rs_rem_before", 32'(rem), 32'd2);
    step("rs_hold0", 1, C_CLEAN, 0, 0);
    step("rs_hold1", 1, C_CLEAN, 0, 0);
    check("rs_rem_in_reset", 32'(rem), 32'd0);
    step("rs_release", 0, C_CLEAN, 0, 0);
    check("rs_rem_restart", 32'(rem), 32'd3);

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      bit r;
      logic [`MODE_WIDTH-1:0] md;
      r  = ($urandom_range(0, 199) == 0);
      md = ($urandom_range(0, 39) == 0) ? C_STAND : C_CLEAN;
      step("rnd", r, md, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clean_mode_controller_exit.md
Name: clean_mode_controller_exit

Overview:
Companion to the clean-mode entry controller. The entry controller raises a toggle that moves the hood from STAND_MODE into CLEAN_MODE; this block raises the toggle that moves it back out.
- While CLEAN_MODE is active, it runs a seconds countdown for the clean cycle.
- It supports an early abort: a menu press followed by a normal press within a confirm window.
- It outputs a level toggle for the mode FSM, done/abort pulses, and the remaining seconds for the display.

Parameters:
- TICKS_PER_SEC, 100_000_000, clk cycles per second (prescaler period), minimum 2.
- CLEAN_SECONDS, 180, clean cycle length in seconds, minimum 1.
- CONFIRM_SECONDS, 5, window after a menu press in which normal_signal confirms an abort, minimum 1.
- SEC_W (localparam), $clog2(CLEAN_SECONDS+1), width of the seconds counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- current_mode  in  `MODE_WIDTH  mode from the mode FSM.
- menu_signal  in  1  debounced menu key, level.
- normal_signal  in  1  debounced normal key, level.
- clean_mode_controller_exit_toggle  out  1  level request to leave CLEAN_MODE.
- clean_done  out  1  one-cycle pulse when the countdown completes.
- clean_aborted  out  1  one-cycle pulse on a confirmed abort.
- confirm_pending  out  1  high while the abort-confirm window is open.
- remaining_seconds  out  SEC_W  seconds left in the cycle; 0 when not running.

Interface rule (already decided): one clock, clk. Reset rst is synchronous and active-high. All state updates on posedge clk; rst is sampled only there.

Behaviour:
- Reset: all outputs 0, state IDLE, prescaler, confirm counter and menu_signal_d all 0.
- menu edge: menu_rise = menu_signal & ~menu_signal_d, where menu_signal_d is a registered copy of menu_signal.
- States: IDLE, RUNNING, CONFIRM, EXIT. All outputs are registered.
- Leaving CLEAN_MODE overrides everything: if current_mode != `CLEAN_MODE, next state is IDLE in any state. Outputs clear next cycle; no done or abort pulse.
- IDLE -> RUNNING when current_mode == `CLEAN_MODE. On that cycle: remaining_seconds <= CLEAN_SECONDS, prescaler <= 0. A menu_rise in the entry cycle is ignored.
- Second tick: the prescaler counts 0..TICKS_PER_SEC-1 in RUNNING and CONFIRM. At the terminal value it wraps to 0, remaining_seconds decrements, and the confirm counter decrements if in CONFIRM.
- RUNNING:
  - menu_rise -> CONFIRM, confirm counter <= CONFIRM_SECONDS, confirm_pending <= 1.
  - The countdown continues unaffected.
- CONFIRM:
  - normal_signal & ~menu_signal -> EXIT, clean_aborted pulses, confirm_pending <= 0.
  - Confirm counter reaching 0 on a tick -> RUNNING, confirm_pending <= 0.
  - A further menu_rise is ignored; it does not restart the window.
- Expiry: a tick with remaining_seconds == 1, in RUNNING or CONFIRM, sets remaining_seconds <= 0 and moves to EXIT. clean_done pulses and confirm_pending <= 0.
- Simultaneous expiry and abort confirmation: expiry wins. clean_done = 1, clean_aborted = 0.
- EXIT:
  - clean_mode_controller_exit_toggle is held at 1 and remaining_seconds holds its value (0 on expiry).
  - The state is left only through the mode-change rule. Toggle clears the cycle after the mode leaves CLEAN_MODE.
- Toggle timing: it rises in the same registered update as the done or abort pulse.
- Reset while running: rst clears everything. If mode is still CLEAN_MODE after rst deasserts, a full CLEAN_SECONDS countdown restarts.
- Width rules: no arithmetic wrap. remaining_seconds never decrements below 0, and the confirm counter saturates at 0.

Decomposition:
- Mode codes (`MODE_WIDTH, `CLEAN_MODE, `STAND_MODE) come from the shared parameters header. Add CLEAN_SECONDS and CONFIRM_SECONDS defaults there as defines.
- The state encoding stays local.
- One natural sub-module: sec_tick_gen. It takes TICKS_PER_SEC, clk, rst and enable, and outputs a one-cycle tick; its count clears when enable is low. It is reusable by the other timers in the hood.

Test Plan:
(All scenarios use TICKS_PER_SEC=4, CLEAN_SECONDS=3, CONFIRM_SECONDS=2; entry into CLEAN_MODE is at cycle 0.)
- Natural completion: mode held CLEAN -> remaining_seconds = 3 at cycle 1, then 2, 1, 0 every 4 cycles. clean_done pulses at the 0 transition and toggle rises with it. Switching mode to STAND -> toggle = 0 the next cycle.
- Abort: menu high 1 cycle at remaining 3, then normal high 1 cycle -> confirm_pending = 1. Then toggle = 1 and clean_aborted pulses; clean_done stays 0 and remaining_seconds is frozen at 3.
- Confirm timeout: menu press, no normal for 2 ticks -> confirm_pending drops, countdown continues. A later normal press has no effect and the cycle completes with clean_done.
- Simultaneous events: normal asserted in the exact cycle the final tick expires while in CONFIRM -> clean_done = 1, clean_aborted = 0, toggle = 1.
- Mode leaves mid-run: mode set to STAND at remaining 2 -> next cycle remaining_seconds = 0 and all outputs 0. Re-entering CLEAN restarts at 3.
- Reset mid-run: rst held 2 cycles at remaining 2 with mode CLEAN -> outputs 0 during rst. After release the countdown restarts at 3.
